// File: rtl/rc5_pkg.sv
// Shared constants, types and sizing helpers for the RC5-16 key-expansion block.
package rc5_pkg;

    localparam int W           = 16;
    localparam int MAX_ROUNDS  = 16;
    localparam int KEY_BITS    = 128;
    localparam int NUM_SUBKEYS = 2 * MAX_ROUNDS + 2;
    localparam int C_WORDS     = KEY_BITS / W;

    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;

    typedef logic [15:0] subkey_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Table length t = 2*min(r,16)+2
    function automatic logic [5:0] table_len(input logic [4:0] r);
        logic [4:0] r_eff;
        r_eff = (r > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : r;
        return {r_eff, 1'b0} + 6'd2;
    endfunction

    // Mixing iterations n = 3*max(t,8)
    function automatic logic [6:0] mix_count(input logic [5:0] t);
        logic [5:0] m;
        m = (t < 6'd8) ? 6'd8 : t;
        return {1'b0, m} + {m, 1'b0};
    endfunction

endpackage

// File: rtl/rc5_key_expand_if.sv
// Request/status and dual read-port bundle between the key expander and its consumer.
interface rc5_key_expand_if;
    import rc5_pkg::*;

    logic                start;
    logic [KEY_BITS-1:0] key;
    logic [4:0]          num_rounds;
    logic                ready;
    logic                done;
    logic                keys_valid;
    logic [5:0]          sk_addr_a;
    subkey_t             sk_data_a;
    logic [5:0]          sk_addr_b;
    subkey_t             sk_data_b;

    modport master (
        output start, key, num_rounds, sk_addr_a, sk_addr_b,
        input  ready, done, keys_valid, sk_data_a, sk_data_b
    );

    modport slave (
        input  start, key, num_rounds, sk_addr_a, sk_addr_b,
        output ready, done, keys_valid, sk_data_a, sk_data_b
    );

endinterface

// File: rtl/rc5_key_expand_rotl.sv
// Combinational left rotate of a W-bit word by a variable amount.
module rc5_key_expand_rotl #(
    parameter  int W  = 16,
    localparam int SH = $clog2(W)
) (
    input  logic [W-1:0]  x_i,
    input  logic [SH-1:0] n_i,
    output logic [W-1:0]  y_o
);

    logic [2*W-1:0] dbl_s;

    // Shifting a doubled word left leaves the rotated word in the upper half
    always_comb begin
        dbl_s = {x_i, x_i} << n_i;
        y_o   = dbl_s[2*W-1:W];
    end

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-16 key expansion: builds S[0..2r+1] from a 128-bit key and a round count,
// holding the table in registers behind two combinational read ports.
module rc5_key_expand
    import rc5_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    rc5_key_expand_if.slave bus
);

    state_e     state_q, state_d;
    subkey_t    s_q [NUM_SUBKEYS];
    subkey_t    s_d [NUM_SUBKEYS];
    subkey_t    l_q [C_WORDS];
    subkey_t    l_d [C_WORDS];
    subkey_t    a_q, a_d;
    subkey_t    b_q, b_d;
    logic [5:0] i_q, i_d;
    logic [5:0] t_q, t_d;
    logic [2:0] j_q, j_d;
    logic [6:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;
    logic       valid_q, valid_d;

    subkey_t    init_word_s;
    subkey_t    mix_a_in_s, a_new_s;
    subkey_t    mix_b_in_s, b_new_s;
    logic [5:0] i_prev_s;
    logic [3:0] b_rot_s;
    logic       i_last_s;

    // First half of a mix step plus the INIT table word
    always_comb begin
        i_prev_s    = i_q - 6'd1;
        init_word_s = (i_q == 6'd0) ? P16 : (s_q[i_prev_s] + Q16);
        i_last_s    = (i_q == (t_q - 6'd1));
        mix_a_in_s  = s_q[i_q] + a_q + b_q;
    end

    rc5_key_expand_rotl #(.W(W)) u_rotl_a (
        .x_i (mix_a_in_s),
        .n_i (4'd3),
        .y_o (a_new_s)
    );

    // Second half of a mix step depends on the freshly rotated A
    always_comb begin
        mix_b_in_s = l_q[j_q] + a_new_s + b_q;
        b_rot_s    = 4'(a_new_s + b_q);
    end

    rc5_key_expand_rotl #(.W(W)) u_rotl_b (
        .x_i (mix_b_in_s),
        .n_i (b_rot_s),
        .y_o (b_new_s)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        l_d     = l_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    for (int k = 0; k < C_WORDS; k++) begin
                        l_d[k] = bus.key[W*k +: W];
                    end
                    t_d     = table_len(bus.num_rounds);
                    a_d     = 16'h0000;
                    b_d     = 16'h0000;
                    i_d     = 6'd0;
                    j_d     = 3'd0;
                    cnt_d   = 7'd0;
                    valid_d = 1'b0;
                    state_d = INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                s_d[i_q] = init_word_s;
                if (i_last_s) begin
                    i_d     = 6'd0;
                    cnt_d   = mix_count(t_q);
                    state_d = MIX;
                end else begin
                    i_d = i_q + 6'd1;
                end
            end
            MIX: begin
                s_d[i_q] = a_new_s;
                l_d[j_q] = b_new_s;
                a_d      = a_new_s;
                b_d      = b_new_s;
                i_d      = i_last_s ? 6'd0 : (i_q + 6'd1);
                j_d      = j_q + 3'd1;
                cnt_d    = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = MIX;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE) || (state_d == DONE);
    end

    // State and table registers; reset aborts any run in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int k = 0; k < NUM_SUBKEYS; k++) begin
                s_q[k] <= 16'h0000;
            end
            for (int k = 0; k < C_WORDS; k++) begin
                l_q[k] <= 16'h0000;
            end
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            i_q     <= 6'd0;
            j_q     <= 3'd0;
            t_q     <= 6'd0;
            cnt_q   <= 7'd0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            l_q     <= l_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Read ports: entries beyond the table depth read as zero
    always_comb begin
        bus.sk_data_a = (bus.sk_addr_a < 6'(NUM_SUBKEYS)) ? s_q[bus.sk_addr_a] : 16'h0000;
        bus.sk_data_b = (bus.sk_addr_b < 6'(NUM_SUBKEYS)) ? s_q[bus.sk_addr_b] : 16'h0000;
    end

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.keys_valid = valid_q;

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed self-checking bench for rc5_key_expand against an independent RC5-16 key schedule model.
module tb_rc5_key_expand;
    import rc5_pkg::*;

    typedef logic [15:0] tbl_t [34];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rc5_key_expand_if bus();

    rc5_key_expand dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    tbl_t exp_s;
    tbl_t dut_s;

    localparam logic [127:0] KEY_ZERO = 128'h0;
    localparam logic [127:0] KEY_ONES = {128{1'b1}};
    localparam logic [127:0] KEY_RAMP = 128'h0F0E0D0C0B0A09080706050403020100;

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
        logic [31:0] v;
        v = {16'h0000, x} << n;
        return v[15:0] | v[31:16];
    endfunction

    function automatic int eff_rounds(input int r);
        return (r > 16) ? 16 : r;
    endfunction

    function automatic int exp_latency(input int r);
        int t;
        t = 2 * eff_rounds(r) + 2;
        return t + 3 * ((t > 8) ? t : 8);
    endfunction

    task automatic build_model(input logic [127:0] k, input int r);
        logic [15:0] l [8];
        logic [15:0] a;
        logic [15:0] b;
        int t;
        int n;
        int ii;
        int jj;
        t = 2 * eff_rounds(r) + 2;
        n = 3 * ((t > 8) ? t : 8);
        for (int q = 0; q < 8; q++) l[q] = k[16*q +: 16];
        exp_s[0] = 16'hB7E1;
        for (int q = 1; q < t; q++) exp_s[q] = exp_s[q-1] + 16'h9E37;
        a = 16'h0000;
        b = 16'h0000;
        ii = 0;
        jj = 0;
        for (int q = 0; q < n; q++) begin
            a = rotl16(exp_s[ii] + a + b, 4'd3);
            exp_s[ii] = a;
            b = rotl16(l[jj] + a + b, 4'(a + b));
            l[jj] = b;
            ii = (ii + 1) % t;
            jj = (jj + 1) % 8;
        end
    endtask

    function automatic logic [31:0] rc5_enc(input logic [31:0] pt, input tbl_t s, input int r);
        logic [15:0] a;
        logic [15:0] b;
        a = pt[15:0] + s[0];
        b = pt[31:16] + s[1];
        for (int i = 1; i <= r; i++) begin
            a = rotl16(a ^ b, b[3:0]) + s[2*i];
            b = rotl16(b ^ a, a[3:0]) + s[2*i+1];
        end
        return {b, a};
    endfunction

    function automatic logic [31:0] rc5_dec(input logic [31:0] ct, input tbl_t s, input int r);
        logic [15:0] a;
        logic [15:0] b;
        a = ct[15:0];
        b = ct[31:16];
        for (int i = r; i >= 1; i--) begin
            b = rotl16(b - s[2*i+1], 4'(4'd0 - a[3:0])) ^ a;
            a = rotl16(a - s[2*i], 4'(4'd0 - b[3:0])) ^ b;
        end
        b = b - s[1];
        a = a - s[0];
        return {b, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic accept(input logic [127:0] k, input int r);
        bus.key        = k;
        bus.num_rounds = 5'(r);
        bus.start      = 1'b1;
        step(1);
        bus.start = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_done(input int exp_lat, input string tag);
        while (bus.done !== 1'b1 && cyc < 400) step(1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_valid"}, {31'd0, bus.keys_valid}, 32'd1);
        check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic check_table(input int r, input string tag);
        int t;
        t = 2 * eff_rounds(r) + 2;
        for (int a = 0; a < t; a++) begin
            bus.sk_addr_a = 6'(a);
            bus.sk_addr_b = 6'(t - 1 - a);
            #1;
            check($sformatf("%s_portA_S%0d", tag, a), {16'h0000, bus.sk_data_a}, {16'h0000, exp_s[a]});
            check($sformatf("%s_portB_S%0d", tag, t - 1 - a), {16'h0000, bus.sk_data_b}, {16'h0000, exp_s[t-1-a]});
        end
    endtask

    task automatic check_zero(input string tag);
        for (int a = 0; a < 34; a++) begin
            bus.sk_addr_a = 6'(a);
            bus.sk_addr_b = 6'(33 - a);
            #1;
            check($sformatf("%s_zeroA_%0d", tag, a), {16'h0000, bus.sk_data_a}, 32'd0);
            check($sformatf("%s_zeroB_%0d", tag, 33 - a), {16'h0000, bus.sk_data_b}, 32'd0);
        end
    endtask

    task automatic check_idle_flags(input string tag);
        check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.keys_valid}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] keys [3];
        int           rs   [3];
        int           seen;
        logic [31:0]  ct_dut;
        logic [31:0]  ct_exp;

        keys[0] = KEY_ZERO;
        keys[1] = KEY_ONES;
        keys[2] = KEY_RAMP;
        rs[0] = 1;
        rs[1] = 12;
        rs[2] = 16;

        bus.start      = 1'b0;
        bus.key        = KEY_ZERO;
        bus.num_rounds = 5'd0;
        bus.sk_addr_a  = 6'd0;
        bus.sk_addr_b  = 6'd0;
        rst = 1'b1;
        #2;
        rst = 1'b0;

        // Reset at idle
        repeat (3) @(posedge clk);
        #1;
        check_idle_flags("rst_idle");
        check_zero("rst_idle");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1);
        check_idle_flags("after_rst");

        // Timing, r=12, single-cycle done
        accept(KEY_ZERO, 12);
        wait_done(104, "r12");
        step(1);
        check("r12_done_pulse", {31'd0, bus.done}, 32'd0);
        check("r12_valid_hold", {31'd0, bus.keys_valid}, 32'd1);
        check("r12_ready_idle", {31'd0, bus.ready}, 32'd1);
        build_model(KEY_ZERO, 12);
        check_table(12, "r12_k0");

        // r=0: INIT contents before the first mix, then latency
        step(1);
        accept(KEY_ZERO, 0);
        step(2);
        bus.sk_addr_a = 6'd0;
        bus.sk_addr_b = 6'd1;
        #1;
        check("init_S0", {16'h0000, bus.sk_data_a}, 32'h0000B7E1);
        check("init_S1", {16'h0000, bus.sk_data_b}, 32'h00005618);
        check("busy_ready", {31'd0, bus.ready}, 32'd0);
        check("busy_valid", {31'd0, bus.keys_valid}, 32'd0);
        wait_done(26, "r0");
        build_model(KEY_ZERO, 0);
        check_table(0, "r0_k0");

        // r=20 clamps to 16
        step(1);
        accept(KEY_ZERO, 20);
        wait_done(136, "r20");
        build_model(KEY_ZERO, 20);
        check_table(20, "r20_k0");

        // Value sweep over keys and round counts
        for (int ki = 0; ki < 3; ki++) begin
            for (int ri = 0; ri < 3; ri++) begin
                step(1);
                accept(keys[ki], rs[ri]);
                wait_done(exp_latency(rs[ri]), $sformatf("sweep_k%0d_r%0d", ki, rs[ri]));
                build_model(keys[ki], rs[ri]);
                check_table(rs[ri], $sformatf("sweep_k%0d_r%0d", ki, rs[ri]));
            end
        end
        bus.sk_addr_a = 6'd34;
        bus.sk_addr_b = 6'd63;
        #1;
        check("oob_34", {16'h0000, bus.sk_data_a}, 32'd0);
        check("oob_63", {16'h0000, bus.sk_data_b}, 32'd0);

        // start during a run is ignored
        step(1);
        accept(KEY_RAMP, 12);
        step(10);
        bus.key        = KEY_ONES;
        bus.num_rounds = 5'd1;
        bus.start      = 1'b1;
        step(1);
        bus.start = 1'b0;
        wait_done(104, "busy_ignore");
        build_model(KEY_RAMP, 12);
        check_table(12, "busy_ignore");

        // Back-to-back re-accept in the DONE cycle
        step(1);
        accept(KEY_ZERO, 1);
        wait_done(28, "b2b_first");
        accept(KEY_ONES, 12);
        check("b2b_done_low", {31'd0, bus.done}, 32'd0);
        check("b2b_valid_low", {31'd0, bus.keys_valid}, 32'd0);
        check("b2b_ready_low", {31'd0, bus.ready}, 32'd0);
        wait_done(104, "b2b_second");
        build_model(KEY_ONES, 12);
        check_table(12, "b2b_second");

        // Round trip through an RC5-16/12 block using the produced table
        for (int a = 0; a < 34; a++) dut_s[a] = 16'h0000;
        for (int a = 0; a < 26; a++) begin
            bus.sk_addr_a = 6'(a);
            #1;
            dut_s[a] = bus.sk_data_a;
        end
        ct_dut = rc5_enc(32'h12345678, dut_s, 12);
        ct_exp = rc5_enc(32'h12345678, exp_s, 12);
        check("rt_ciphertext", ct_dut, ct_exp);
        check("rt_plaintext", rc5_dec(ct_dut, dut_s, 12), 32'h12345678);

        // Reset mid-run aborts with no done pulse
        step(1);
        accept(KEY_RAMP, 16);
        step(50);
        rst = 1'b0;
        #1;
        check_idle_flags("rst_mid");
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 0;
        repeat (150) begin
            step(1);
            if (bus.done === 1'b1) seen++;
        end
        check("rst_mid_no_done", seen, 0);
        check_idle_flags("rst_mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rc5_key_expand.md
Name: rc5_key_expand

Overview:
- RC5-16 key-expansion stage; sits directly upstream of the RC5 round engine.
- Turns a 128-bit user key and a round count into the subkey table S[0..2r+1].
- Holds the table in registers and serves it through two combinational read ports, so the engine can fetch S[2k] and S[2k+1] in the same cycle.

Parameters:
- W, 16, word width in bits (RC5-16).
- MAX_ROUNDS, 16, largest supported round count; table depth = 2*MAX_ROUNDS+2 = 34.
- KEY_BITS, 128, user key width; C = KEY_BITS/W = 8 key words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request expansion; sampled only while ready=1.
- key  in  128  user key; key[7:0] is byte 0.
- num_rounds  in  5  round count r, not 0-indexed; values >16 are treated as 16.
- ready  out  1  high in IDLE and DONE states.
- done  out  1  one-cycle pulse when the table is complete.
- keys_valid  out  1  level; table is coherent for the captured key/r.
- sk_addr_a  in  6  read address, port A.
- sk_data_a  out  16  S[sk_addr_a]; 0 if addr >= 34.
- sk_addr_b  in  6  read address, port B.
- sk_data_b  out  16  S[sk_addr_b]; 0 if addr >= 34.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE; S[0..33], L[0..7], A, B, i, j, counter all cleared.
- done=0, keys_valid=0, ready=1.
- Reset mid-operation aborts immediately; no done pulse follows.

Accept:
- start=1 with ready=1 (IDLE or DONE) at edge E0.
- Capture L[j] = key[16j+15:16j] for j=0..7.
- Capture t = 2*min(r,16)+2.
- Clear A, B, i, j; set keys_valid=0; go to INIT.
- start is ignored in INIT and MIX.

INIT (t cycles, edges E1..Et):
- S[i] <= (i==0) ? P16 : S[i-1]+Q16, with P16=0xB7E1 and Q16=0x9E37; i increments each edge.
- On the last edge: i=0, counter=n=3*max(t,8); go to MIX.

MIX (n cycles, one iteration per edge):
- a' = rotl(S[i]+A+B, 3); b' = rotl(L[j]+a'+B, (a'+B) mod 16).
- Update S[i]=a', A=a', L[j]=b', B=b'.
- i=(i+1) mod t; j=(j+1) mod 8.
- All additions are mod 2^16; the rotate amount is the low 4 bits.
- After the final iteration, go to DONE.

DONE:
- done=1 for exactly one cycle; keys_valid=1.
- Next state is IDLE, or INIT again if start=1 is accepted.

Latency and storage:
- done is high in the cycle after edge E(t+n).
- r=0: t=2, n=24, 26 cycles. r=12: t=26, n=78, 104 cycles. r=16: t=34, n=102, 136 cycles.
- Entries S[t..33] keep stale values from earlier runs; the consumer never indexes past 2r+1.

Read ports:
- Purely combinational from the S registers; readable at any time.
- Reads during INIT/MIX return in-progress values; keys_valid=0 flags this.
- Both ports may address the same entry.

Key changes:
- key and num_rounds are sampled only at accept; later changes have no effect until the next start.

Decomposition:
Package rc5_pkg holds:
- W, MAX_ROUNDS, NUM_SUBKEYS=34, C_WORDS=8.
- P16=16'hB7E1, Q16=16'h9E37.
- typedef subkey_t (logic [15:0]).
- State enum {IDLE, INIT, MIX, DONE}.

Sub-modules:
- Reuse the existing rotl twice: one instance with n_i fixed to 3, one with n_i=(a'+B).
- No new sub-module is required.

Test Plan:
- Reset: hold rst=0 for 3 cycles, mid-run and at idle -> ready=1, done=0, keys_valid=0, sk_data_a=sk_data_b=0 for every address 0..33.
- Timing: key=0, r=12, start pulse -> done exactly 104 cycles after the accept edge, single-cycle done, keys_valid=1, ready=1. Repeat with r=0 -> 26 cycles and r=20 -> 136 cycles (clamped to 16).
- Value check: keys {0, all-ones, 0x000102..0F byte-ramp}, r in {1,12,16} -> S[0..2r+1] on both ports match the C golden model bit-exactly. sk_addr 34 and 63 return 0.
- Busy ignore: assert start again at cycle 10 of a run with a different key -> no restart; done still at the original cycle; table matches the first key.
- Back-to-back: start held high in the DONE cycle with a new key -> immediate re-accept; keys_valid drops next cycle; second done at the expected latency; new table correct.
- Round-trip: feed the table to the round engine, encrypt 0x12345678 with r=12, then decrypt -> 0x12345678 recovered.
